// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM state
// encoding and opcode classification helpers.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {S_IDLE, S_ONE, S_MUL, S_DIV, S_FIN} state_t;

  // Ops that go through the iterative core (div by zero short-circuits).
  function automatic logic is_iter(input logic [4:0] op, input logic b_zero);
    return (op == OP_MUL) || (op == OP_DIV && !b_zero);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Issue/result bus of the sequential ALU. The control unit drives the
// master side (start, opcode, operands); the ALU is the slave and returns
// busy/done, the {HI,LO} result and status flags.
interface seq_alu_if #(parameter int WIDTH = 32);
  logic               start;
  logic [4:0]         opcode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;
  logic               illegal_op;

  modport master (output start, opcode, a, b,
                  input  busy, done, result, div_by_zero, illegal_op);
  modport slave  (input  start, opcode, a, b,
                  output busy, done, result, div_by_zero, illegal_op);
endinterface

// File: rtl/seq_muldiv_core.sv
// Bit-serial signed multiply (radix-2 Booth) and divide (non-restoring on
// magnitudes, sign-corrected at the end). One iteration per clock.
//   go     : load a/b and start WIDTH iterations
//   is_div : select divide (1) or multiply (0), sampled with go
//   last   : high during the final iteration
//   hi/lo  : product, or remainder/quotient; valid the cycle after last
module seq_muldiv_core #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             clr,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  logic             run, div_q, qm1, neg_q, neg_r;
  logic [CW-1:0]    cnt;
  // Two guard bits: Booth needs one for -2^(W-1) operands, the divider
  // needs two because the shifted partial remainder reaches +/-2^W.
  logic [WIDTH+1:0] acc, m, sum, shl, acc_nx;
  logic [WIDTH-1:0] q, q_nx, a_mag, b_mag, rem;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign last  = run && (cnt == CW'(WIDTH-1));

  always_comb begin
    shl    = {acc[WIDTH:0], q[WIDTH-1]};
    sum    = acc;
    acc_nx = acc;
    q_nx   = q;
    if (div_q) begin
      // Non-restoring: add back when the remainder is negative.
      sum    = acc[WIDTH+1] ? shl + m : shl - m;
      acc_nx = sum;
      q_nx   = {q[WIDTH-2:0], ~sum[WIDTH+1]};
    end else begin
      case ({q[0], qm1})
        2'b01:   sum = acc + m;
        2'b10:   sum = acc - m;
        default: sum = acc;
      endcase
      acc_nx = {sum[WIDTH+1], sum[WIDTH+1:1]};
      q_nx   = {sum[0], q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      run <= 1'b0; cnt <= '0; div_q <= 1'b0; qm1 <= 1'b0;
      neg_q <= 1'b0; neg_r <= 1'b0; acc <= '0; q <= '0; m <= '0;
    end else if (go) begin
      run   <= 1'b1;
      cnt   <= '0;
      div_q <= is_div;
      acc   <= '0;
      qm1   <= 1'b0;
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
      q     <= is_div ? a_mag : a;
      m     <= is_div ? {2'b00, b_mag} : {{2{b[WIDTH-1]}}, b};
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (last) run <= 1'b0;
      acc <= acc_nx;
      q   <= q_nx;
      qm1 <= q[0];
    end
  end

  // Final restore of a negative remainder, then apply operand signs.
  // |-2^(W-1) / -1| wraps back to -2^(W-1) naturally.
  assign rem = acc[WIDTH+1] ? acc[WIDTH-1:0] + m[WIDTH-1:0] : acc[WIDTH-1:0];

  always_comb begin
    if (div_q) begin
      hi = neg_r ? -rem : rem;
      lo = neg_q ? -q : q;
    end else begin
      hi = acc[WIDTH-1:0];
      lo = q;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the Z (HI/LO) pair. Single-cycle ops complete
// one edge after issue; mul/div run through seq_muldiv_core and complete
// WIDTH+1 edges after issue.
//   clk, clr : clock, asynchronous active-high reset
//   bus      : start/opcode/a/b in; busy/done/result/div_by_zero/illegal_op out
module seq_alu
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic     clk,
  input  logic     clr,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic               busy_q, done_q, dz_q, ill_q;
  logic [2*WIDTH-1:0] res_q;
  logic [4:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;

  logic               go, b_zero;
  logic               core_last;
  logic [WIDTH-1:0]   core_hi, core_lo;

  logic [WIDTH-1:0]   one_lo, one_hi;
  logic               one_dz, one_ill;
  logic [2*WIDTH-1:0] rot;
  logic [SHW-1:0]     amt;

  assign b_zero = (bus.b == '0);
  assign go     = bus.start && !busy_q && is_iter(bus.opcode, b_zero);

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .clr    (clr),
    .go     (go),
    .is_div (bus.opcode == OP_DIV),
    .a      (bus.a),
    .b      (bus.b),
    .last   (core_last),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // Single-cycle datapath on the latched operands.
  assign amt = b_r[SHW-1:0];

  always_comb begin
    one_lo  = '0;
    one_hi  = '0;
    one_dz  = 1'b0;
    one_ill = 1'b0;
    rot     = '0;
    case (op_r)
      OP_ADD:  one_lo = a_r + b_r;
      OP_SUB:  one_lo = a_r - b_r;
      OP_SHR:  one_lo = a_r >> amt;
      OP_SHRA: one_lo = $signed(a_r) >>> amt;
      OP_SHL:  one_lo = a_r << amt;
      OP_ROR:  begin rot = {a_r, a_r} >> amt; one_lo = rot[WIDTH-1:0]; end
      OP_ROL:  begin rot = {a_r, a_r} << amt; one_lo = rot[2*WIDTH-1:WIDTH]; end
      OP_AND:  one_lo = a_r & b_r;
      OP_OR:   one_lo = a_r | b_r;
      OP_NEG:  one_lo = -b_r;
      OP_NOT:  one_lo = ~b_r;
      OP_MUL:  ;
      // Only divide-by-zero reaches the single-cycle path.
      OP_DIV:  begin one_lo = '1; one_hi = a_r; one_dz = 1'b1; end
      default: one_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE; busy_q <= 1'b0; done_q <= 1'b0; dz_q <= 1'b0;
      ill_q <= 1'b0; res_q <= '0; op_r <= '0; a_r <= '0; b_r <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          op_r   <= bus.opcode;
          a_r    <= bus.a;
          b_r    <= bus.b;
          dz_q   <= 1'b0;
          ill_q  <= 1'b0;
          busy_q <= 1'b1;
          if (bus.opcode == OP_MUL)                  state <= S_MUL;
          else if (bus.opcode == OP_DIV && !b_zero)  state <= S_DIV;
          else                                       state <= S_ONE;
        end
        S_ONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          res_q  <= {one_hi, one_lo};
          dz_q   <= one_dz;
          ill_q  <= one_ill;
        end
        S_MUL, S_DIV: if (core_last) state <= S_FIN;
        S_FIN: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          res_q  <= {core_hi, core_lo};
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = res_q;
  assign bus.div_by_zero = dz_q;
  assign bus.illegal_op  = ill_q;
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model from the arithmetic definitions.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] r, output logic dz, output logic il, output int lat);
    longint sa, sb, qq, rr;
    logic [31:0] x;
    int amt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    amt = int'(b[4:0]);
    r = 64'h0; dz = 1'b0; il = 1'b0; lat = 1;
    x = a;
    case (op)
      5'b00011: r = {32'h0, a + b};
      5'b00100: r = {32'h0, a - b};
      5'b00101: r = {32'h0, a >> amt};
      5'b00110: r = {32'h0, 32'($signed(a) >>> amt)};
      5'b00111: r = {32'h0, a << amt};
      5'b01000: begin for (int i = 0; i < amt; i++) x = {x[0], x[31:1]}; r = {32'h0, x}; end
      5'b01001: begin for (int i = 0; i < amt; i++) x = {x[30:0], x[31]}; r = {32'h0, x}; end
      5'b01010: r = {32'h0, a & b};
      5'b01011: r = {32'h0, a | b};
      5'b01111: begin r = 64'(sa * sb); lat = 33; end
      5'b10000: begin
        if (b == 32'h0) begin r = {a, 32'hFFFFFFFF}; dz = 1'b1; end
        else begin
          qq = sa / sb; rr = sa % sb;
          r = {rr[31:0], qq[31:0]};
          lat = 33;
        end
      end
      5'b10001: r = {32'h0, 32'h0 - b};
      5'b10010: r = {32'h0, ~b};
      default:  il = 1'b1;
    endcase
  endtask

  // Issue one op, scramble inputs while busy (including a stray start),
  // and return in the cycle where done is high.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] av,
                        input logic [31:0] bv);
    logic [63:0] er;
    logic ed, ei;
    int elat, lat;
    bit seen;
    model(op, av, bv, er, ed, ei, elat);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.opcode = 5'($urandom);
    chk({tag, ".busy_issue"}, 64'(bus.busy), 64'h1);
    lat = 0; seen = 0;
    while (lat < 40 && !seen) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1;
      else begin
        bus.a = $urandom; bus.b = $urandom;
        bus.start = (lat == 3);
      end
    end
    bus.start = 1'b0;
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".result"}, bus.result, er);
    chk({tag, ".dz"}, 64'(bus.div_by_zero), 64'(ed));
    chk({tag, ".ill"}, 64'(bus.illegal_op), 64'(ei));
    chk({tag, ".busy_done"}, 64'(bus.busy), 64'h0);
  endtask

  logic [4:0] ops [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                           5'd15, 5'd16, 5'd17, 5'd18, 5'd0};

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.opcode = 5'h0; bus.a = 32'h0; bus.b = 32'h0;
    #12;
    chk("rst.busy", 64'(bus.busy), 64'h0);
    chk("rst.done", 64'(bus.done), 64'h0);
    chk("rst.result", bus.result, 64'h0);
    chk("rst.flags", {62'h0, bus.div_by_zero, bus.illegal_op}, 64'h0);
    @(negedge clk); clr = 1'b0;

    run_op("add_wrap", 5'b00011, 32'hFFFFFFFF, 32'h1);
    run_op("mul_neg",  5'b01111, 32'hFFFFFFFD, 32'h5);
    run_op("div_neg",  5'b10000, 32'hFFFFFFF9, 32'h2);
    run_op("div_ovf",  5'b10000, 32'h80000000, 32'hFFFFFFFF);
    run_op("div_zero", 5'b10000, 32'h9, 32'h0);
    run_op("add_clr",  5'b00011, 32'h10, 32'h20);
    run_op("shra",     5'b00110, 32'h80000010, 32'h24);
    run_op("shra0",    5'b00110, 32'h80000010, 32'h20);
    run_op("rol",      5'b01001, 32'h80000001, 32'h1);
    run_op("ror",      5'b01000, 32'h80000001, 32'h3);
    run_op("illegal",  5'b00000, 32'h1234, 32'h5678);
    run_op("mul_min",  5'b01111, 32'h80000000, 32'h80000000);

    // Back-to-back: start raised in the done cycle is accepted.
    bus.start = 1'b1; bus.opcode = 5'b01011; bus.a = 32'hF0; bus.b = 32'h0F;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b.busy", 64'(bus.busy), 64'h1);
    chk("b2b.done_low", 64'(bus.done), 64'h0);
    @(posedge clk); #1;
    chk("b2b.done", 64'(bus.done), 64'h1);
    chk("b2b.result", bus.result, 64'h0000_0000_0000_00FF);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 5'b01111; bus.a = 32'h7; bus.b = 32'h9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    clr = 1'b1; #1;
    chk("abort.busy", 64'(bus.busy), 64'h0);
    chk("abort.result", bus.result, 64'h0);
    chk("abort.done", 64'(bus.done), 64'h0);
    @(negedge clk); clr = 1'b0;
    run_op("post_abort", 5'b01111, 32'h7, 32'h9);

    // Randomized ops, biased towards edge operands now and then.
    for (int n = 0; n < 40; n++) begin
      rop = ops[$urandom_range(0, 13)];
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = 32'($urandom_range(0, 40));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
